// File: rtl/bus_arbiter_pkg.sv
// Shared codes for the L2 bus arbiter: FSM state encodings, request type codes
// and a sizing helper for the shared grant-window / turnaround counter.
package bus_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_GRANT = 2'd1;
    localparam logic [1:0] ARB_OWNED = 2'd2;
    localparam logic [1:0] ARB_TURN  = 2'd3;

    localparam logic REQ_NORMAL = 1'b0;
    localparam logic REQ_PWB    = 1'b1;

    // Bits needed to hold a down-counter preloaded with max_val-1.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/bus_arbiter_picker.sv
// Combinational round-robin picker: returns the first set candidate found
// searching upward from rr_ptr+1, wrapping from NUM_REQ-1 back to 0.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] cand,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               valid,
    output logic [ID_W-1:0]    winner
);

    always_comb begin
        int              idx;
        logic [ID_W-1:0] sel;
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        sel    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            sel = idx[ID_W-1:0];
            if (!valid && cand[sel]) begin
                valid  = 1'b1;
                winner = sel;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Arbiter for one shared L2 bus: PWB-over-normal priority, round-robin within a
// class, grant/hold handshake with revoke on window expiry and a turnaround gap.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int GRANT_WINDOW = 4,
    parameter int TURNAROUND   = 1,
    parameter int ID_W         = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] bus_req,
    input  logic [NUM_REQ-1:0] bus_req_type,
    input  logic [NUM_REQ-1:0] bus_hold,
    output logic [NUM_REQ-1:0] bus_get,
    output logic               bus_active,
    output logic [ID_W-1:0]    bus_owner,
    output logic               grant_revoked
);

    localparam int CNT_MAX = (GRANT_WINDOW > TURNAROUND) ? GRANT_WINDOW : TURNAROUND;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] GW_LOAD = CNT_W'(GRANT_WINDOW - 1);
    localparam logic [CNT_W-1:0] TA_LOAD = CNT_W'(TURNAROUND - 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] get_q, get_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic               revoked_q, revoked_d;

    logic [NUM_REQ-1:0] pwb_req;
    logic [NUM_REQ-1:0] cand;
    logic               pick_valid;
    logic [ID_W-1:0]    pick_winner;
    logic               owner_req;
    logic               owner_hold;

    always_comb begin
        pwb_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pwb_req[i] = bus_req[i] && (bus_req_type[i] == REQ_PWB);
        end
        cand = (pwb_req != '0) ? pwb_req : bus_req;
    end

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .cand    (cand),
        .rr_ptr  (rr_ptr_q),
        .valid   (pick_valid),
        .winner  (pick_winner)
    );

    assign owner_req  = bus_req[owner_q];
    assign owner_hold = bus_hold[owner_q];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_ptr_d  = rr_ptr_q;
        get_d     = get_q;
        owner_d   = owner_q;
        revoked_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    get_d              = '0;
                    get_d[pick_winner] = 1'b1;
                    owner_d            = pick_winner;
                    rr_ptr_d           = pick_winner;
                    cnt_d              = GW_LOAD;
                    state_d            = ARB_GRANT;
                end
            end
            // Priority: request drop, then hold (beats a same-cycle expiry), then revoke.
            ARB_GRANT: begin
                if (!owner_req) begin
                    get_d   = '0;
                    cnt_d   = TA_LOAD;
                    state_d = ARB_TURN;
                end else if (owner_hold) begin
                    state_d = ARB_OWNED;
                end else if (cnt_q == '0) begin
                    get_d     = '0;
                    revoked_d = 1'b1;
                    cnt_d     = TA_LOAD;
                    state_d   = ARB_TURN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ARB_OWNED: begin
                if (!owner_req || !owner_hold) begin
                    get_d   = '0;
                    cnt_d   = TA_LOAD;
                    state_d = ARB_TURN;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            cnt_q     <= '0;
            rr_ptr_q  <= ID_W'(NUM_REQ - 1);
            get_q     <= '0;
            owner_q   <= '0;
            revoked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            get_q     <= get_d;
            owner_q   <= owner_d;
            revoked_q <= revoked_d;
        end
    end

    assign bus_get       = get_q;
    assign bus_owner     = owner_q;
    assign grant_revoked = revoked_q;
    assign bus_active    = (state_q == ARB_GRANT) || (state_q == ARB_OWNED);

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected grantees are queued as requests are
// driven and popped whenever a new grant appears on bus_get.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] bus_req;
    logic [3:0] bus_req_type;
    logic [3:0] bus_hold;
    logic [3:0] bus_get;
    logic       bus_active;
    logic [1:0] bus_owner;
    logic       grant_revoked;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    bus_arbiter #(
        .NUM_REQ      (4),
        .GRANT_WINDOW (4),
        .TURNAROUND   (1),
        .ID_W         (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus_req       (bus_req),
        .bus_req_type  (bus_req_type),
        .bus_hold      (bus_hold),
        .bus_get       (bus_get),
        .bus_active    (bus_active),
        .bus_owner     (bus_owner),
        .grant_revoked (grant_revoked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Grant monitor: every new grant must match the head of the scoreboard.
    initial begin
        logic [3:0] prev_get;
        int         e;
        prev_get = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_get = '0;
            end else begin
                if (bus_get != '0 && prev_get == '0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_grant", {28'd0, bus_get}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("grant_owner", {30'd0, bus_owner}, e);
                        check("grant_onehot", {28'd0, bus_get}, 32'd1 << e);
                    end
                end
                prev_get = bus_get;
            end
        end
    end

    task automatic do_reset();
        bus_req      = '0;
        bus_hold     = '0;
        bus_req_type = {4{REQ_NORMAL}};
        rst          = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int c = 0; c < 50 && idx < 0; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (bus_get[k] && idx < 0) idx = k;
            end
        end
        if (idx < 0) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic serve(input int hold_cycles, output int idx);
        wait_grant(idx);
        if (idx >= 0) begin
            bus_hold[idx] = 1'b1;
            repeat (hold_cycles) @(negedge clk);
            bus_req[idx]  = 1'b0;
            bus_hold[idx] = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        rst          = 1'b1;
        bus_req      = '0;
        bus_hold     = '0;
        bus_req_type = '0;
        @(negedge clk);
        check("rst_get", {28'd0, bus_get}, 32'd0);
        check("rst_active", {31'd0, bus_active}, 32'd0);
        check("rst_owner", {30'd0, bus_owner}, 32'd0);
        check("rst_revoked", {31'd0, grant_revoked}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single requester: one-edge latency, hold, release, turnaround gap.
        exp_q.push_back(0);
        bus_req = 4'b0001;
        @(negedge clk);
        check("t1_get", {28'd0, bus_get}, 32'h1);
        check("t1_active", {31'd0, bus_active}, 32'd1);
        bus_hold = 4'b0001;
        repeat (4) @(negedge clk);
        check("t1_owned", {28'd0, bus_get}, 32'h1);
        bus_req  = '0;
        bus_hold = '0;
        @(negedge clk);
        check("t1_release", {27'd0, bus_active, bus_get}, 32'd0);
        check("t1_owner_kept", {30'd0, bus_owner}, 32'd0);
        exp_q.push_back(1);
        bus_req = 4'b0010;
        @(negedge clk);
        check("t1_turnaround", {28'd0, bus_get}, 32'd0);
        @(negedge clk);
        check("t1_next_grant", {28'd0, bus_get}, 32'h2);
        bus_req = '0;
        repeat (3) @(negedge clk);

        // All four normal requesters: round-robin 0,1,2,3,0.
        do_reset();
        bus_req = 4'b1111;
        for (int g = 0; g < 5; g++) exp_q.push_back(g % 4);
        for (int g = 0; g < 5; g++) begin
            serve(3, idx);
            if (g < 4 && idx >= 0) bus_req[idx] = 1'b1;
        end
        bus_req = '0;
        repeat (3) @(negedge clk);

        // PWB outranks a normal request pending at release; no preemption.
        do_reset();
        exp_q.push_back(0);
        bus_req = 4'b0001;
        wait_grant(idx);
        bus_hold = 4'b0001;
        @(negedge clk);
        bus_req[1]      = 1'b1;
        bus_req[3]      = 1'b1;
        bus_req_type[3] = REQ_PWB;
        exp_q.push_back(3);
        exp_q.push_back(1);
        @(negedge clk);
        check("t3_no_preempt", {28'd0, bus_get}, 32'h1);
        @(negedge clk);
        bus_req[0]  = 1'b0;
        bus_hold[0] = 1'b0;
        @(negedge clk);
        serve(2, idx);
        bus_req_type = {4{REQ_NORMAL}};
        serve(2, idx);
        repeat (3) @(negedge clk);

        // Grant window expiry: revoke pulse, then rr_ptr=2 favours requester 3.
        do_reset();
        exp_q.push_back(2);
        bus_req = 4'b0100;
        wait_grant(idx);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_window", {27'd0, grant_revoked, bus_get}, 32'h04);
        end
        @(negedge clk);
        check("t4_revoke", {27'd0, grant_revoked, bus_get}, 32'h10);
        bus_req = 4'b1101;
        exp_q.push_back(3);
        exp_q.push_back(0);
        exp_q.push_back(2);
        @(negedge clk);
        check("t4_pulse_end", {31'd0, grant_revoked}, 32'd0);
        for (int k = 0; k < 3; k++) serve(2, idx);
        bus_req = '0;
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of ownership.
        do_reset();
        exp_q.push_back(2);
        bus_req = 4'b0100;
        wait_grant(idx);
        bus_hold = 4'b0100;
        repeat (2) @(negedge clk);
        check("t5_owned", {27'd0, bus_active, bus_get}, 32'h14);
        #2 rst = 1'b1;
        #1;
        check("t5_async_get", {28'd0, bus_get}, 32'd0);
        check("t5_async_active", {31'd0, bus_active}, 32'd0);
        bus_hold = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(2);
        @(negedge clk);
        check("t5_regrant", {28'd0, bus_get}, 32'h4);
        bus_req = '0;
        repeat (3) @(negedge clk);

        // Hold arriving exactly as the window counter reaches zero wins.
        do_reset();
        exp_q.push_back(1);
        bus_req = 4'b0010;
        wait_grant(idx);
        repeat (3) @(negedge clk);
        bus_hold = 4'b0010;
        @(negedge clk);
        check("t6_hold_wins", {26'd0, bus_active, grant_revoked, bus_get}, 32'h22);
        @(negedge clk);
        check("t6_owned", {28'd0, bus_get}, 32'h2);
        bus_req = '0;
        @(negedge clk);
        check("t6_req_drop", {27'd0, grant_revoked, bus_get}, 32'd0);
        bus_hold = '0;
        repeat (4) @(negedge clk);

        check("sb_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
